// File: rtl/suma_bcd_param.sv
// BCD operand entry and digit-serial adder (A+B, LSD first) for the keypad calculator.
// Optional SUMA_BCD_ACUM_EN: guardar in FIN chains the result into operand A.
module suma_bcd_param #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [3:0]            entrada,
  input  logic                  guardar,
  output logic [4*DIGITS-1:0]   numero,
  output logic [4*DIGITS-1:0]   numero_sv,
  output logic [4*DIGITS+3:0]   resultado,
  output logic                  ocupado,
  output logic                  listo,
  output logic                  desborde
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {ENT_A, ENT_B, SUMA, FIN} state_t;

  state_t          state_q;
  logic [W-1:0]    numero_q;
  logic [W-1:0]    numero_sv_q;
  logic [W+3:0]    resultado_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   idx_q;
  logic            carry_q;
  logic            ocupado_q;
  logic            listo_q;
  logic            desborde_q;
  logic            done_q;

  logic            digit_ok;
  logic            can_add;
  logic            last;
  logic [W-1:0]    numero_shl;
  logic [3:0]      a_dig;
  logic [3:0]      b_dig;
  logic [4:0]      sum5;
  logic [4:0]      sum_adj;
  logic            carry_d;
  logic [3:0]      dig;
  logic [W+3:0]    resultado_wr;

  always_comb begin
    digit_ok   = push && (entrada <= 4'd9);
    can_add    = digit_ok && (cnt_q < CW'(DIGITS));
    last       = (idx_q == CW'(DIGITS - 1));
    // Shift-left form avoids an empty slice when DIGITS == 1
    numero_shl = (numero_q << 4) | W'(entrada);

    a_dig = '0;
    b_dig = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == CW'(k)) begin
        a_dig = numero_sv_q[4*k +: 4];
        b_dig = numero_q[4*k +: 4];
      end
    end

    sum5    = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, carry_q};
    sum_adj = sum5 + 5'd6;
    carry_d = (sum5 > 5'd9);
    dig     = carry_d ? sum_adj[3:0] : sum5[3:0];

    resultado_wr = resultado_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == CW'(k)) begin
        resultado_wr[4*k +: 4] = dig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ENT_A;
      numero_q    <= '0;
      numero_sv_q <= '0;
      resultado_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      desborde_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // listo trails the final SUMA edge by one cycle
      listo_q <= done_q;
      done_q  <= 1'b0;
      case (state_q)
        ENT_A: begin
          if (guardar) begin
            numero_sv_q <= numero_q;
            numero_q    <= '0;
            cnt_q       <= '0;
            state_q     <= ENT_B;
          end else if (can_add) begin
            numero_q <= numero_shl;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        ENT_B: begin
          if (guardar) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            resultado_q <= '0;
            desborde_q  <= 1'b0;
            ocupado_q   <= 1'b1;
            state_q     <= SUMA;
          end else if (can_add) begin
            numero_q <= numero_shl;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        SUMA: begin
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            resultado_q <= {3'b000, carry_d, resultado_wr[W-1:0]};
            desborde_q  <= carry_d;
            ocupado_q   <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= FIN;
          end else begin
            resultado_q <= resultado_wr;
          end
        end
        FIN: begin
`ifdef SUMA_BCD_ACUM_EN
          if (guardar && !desborde_q) begin
            numero_sv_q <= resultado_q[W-1:0];
            numero_q    <= '0;
            cnt_q       <= '0;
            state_q     <= ENT_B;
          end else if (digit_ok) begin
            numero_q    <= W'(entrada);
            cnt_q       <= CW'(1);
            numero_sv_q <= '0;
            state_q     <= ENT_A;
          end
`else
          if (digit_ok) begin
            numero_q    <= W'(entrada);
            cnt_q       <= CW'(1);
            numero_sv_q <= '0;
            state_q     <= ENT_A;
          end
`endif
        end
        default: state_q <= ENT_A;
      endcase
    end
  end

  assign numero    = numero_q;
  assign numero_sv = numero_sv_q;
  assign resultado = resultado_q;
  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign desborde  = desborde_q;

endmodule
